// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: bridges one sized access per instruction
// onto a word-addressed request/ready + rvalid bus and stalls until it completes.
module dmem_responder #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    output logic [31:0]       dout,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_dout;
    logic              r_mis;
    logic              r_err;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;

    logic        w_req;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;
    logic        w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_unused = &{1'b0, addr[31:ADDR_W+2]};

    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = wdata;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~addr[0];
                w_be      = 4'b0011 << {addr[1], 1'b0};
                w_wdata   = {2{wdata[15:0]}};
            end
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Lane select uses the byte offset latched with the request.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'b00:   w_ldata = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ldata = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ldata = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_dout  <= 32'h0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_be    <= 4'b0000;
        end else begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_aligned) begin
                        r_mis <= 1'b1;
                    end else if (w_req) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_we    <= mem_write;
                        r_addr  <= addr[ADDR_W+1:2];
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_off   <= addr[1:0];
                        r_size  <= size;
                        r_uns   <= unsigned_ld;
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Data arriving on the timeout cycle still wins.
                    if (bus_rvalid) begin
                        r_dout  <= w_ldata;
                        r_state <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_dout  <= 32'hDEADBEEF;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall = rstn &
                   ((r_state == S_IDLE && w_req && w_aligned) ||
                    r_state == S_REQ || r_state == S_WAIT);

    assign dout       = r_dout;
    assign misaligned = r_mis;
    assign bus_err    = r_err;
    assign bus_req    = r_req;
    assign bus_we     = r_we;
    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;
    assign bus_be     = r_be;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the memory-stage load/store interface: accepts one load or store per instruction from the memory-access stage and drives its read-data input (`dout`).
- Bridges that request to a variable-latency word-addressed memory bus using request/ready and rvalid handshakes.
- Handles byte/half/word sizing, store byte-enable generation and load sign/zero extension.
- Holds the pipeline via `stall` until each access completes.

Parameters:
- ADDR_W, 16, word-address width on the bus; the byte address bits used are [ADDR_W+1:2].
- TIMEOUT, 1023, maximum cycles spent in WAIT before a read is aborted with an error.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mem_read  in  1  load request from memory stage
- mem_write  in  1  store request from memory stage
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, LSB-aligned
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend
- dout  out  32  extended load data to memory stage
- stall  out  1  pipeline hold
- misaligned  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on read timeout
- bus_req  out  1  bus request valid
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word address
- bus_wdata  out  32  lane-shifted store data
- bus_be  out  4  byte enables
- bus_ready  in  1  bus accepts request
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, rstn low): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, dout=0, misaligned=0, bus_err=0, counter=0. stall is 0 during reset.
- Reset mid-transaction: abandons the transaction; a bus_rvalid arriving afterwards is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, with mem_write or mem_read high:
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned: no bus transaction, misaligned pulses next cycle, stall=0, dout unchanged.
  - Aligned: latch addr, size, unsigned_ld, read/write kind, lane-shifted wdata and bus_be; go to REQ.
  - stall=1 combinationally in the same cycle.
  - mem_read and mem_write both high: treated as a store.
- REQ:
  - bus_req=1 with stable bus_addr/bus_we/bus_wdata/bus_be until bus_ready is sampled high.
  - On accept: store goes to DONE; load goes to WAIT with counter cleared.
  - stall=1.
- WAIT:
  - stall=1; counter increments each cycle.
  - On bus_rvalid: select lane by addr[1:0] and size, extend per unsigned_ld, register into dout, go to DONE.
  - If counter reaches TIMEOUT without rvalid: dout=32'hDEADBEEF, bus_err pulses, go to DONE.
  - rvalid on the same cycle as counter==TIMEOUT: data wins, no bus_err.
- DONE:
  - stall=0 for exactly one cycle, letting the pipeline advance; request inputs are ignored (same instruction).
  - Next state is IDLE.
  - Minimum cost per access: store 3 cycles, load 4 cycles, assuming immediate ready/rvalid.
- Byte enables: byte → 0001<<addr[1:0]; half → 0011<<{addr[1],0}; word → 1111. bus_wdata = wdata replicated into the selected lanes.
- Load extension: byte uses bit 7 of the lane; half uses bit 15.
- bus_req is low in all states except REQ.
- dout holds the last load result until the next load completes; stores never change dout.
- The pipeline keeps its inputs stable while stall=1.

Test Plan:
- Word load at addr 0x0000_0010, ready immediate, rvalid 2 cycles later with 0x89AB_CDEF:
  - bus_addr=4, bus_be=1111.
  - dout=0x89AB_CDEF, stall high 4 cycles then low 1.
- Byte store wdata=0x0000_00A5, addr 0x103:
  - bus_be=1000, bus_wdata=0xA5A5_A5A5, bus_we=1, bus_addr=0x40.
  - No change to dout.
- Signed half load, addr 0x6, rdata 0x8001_1234:
  - unsigned_ld=0 → dout=0xFFFF_8001.
  - unsigned_ld=1 → dout=0x0000_8001.
- Misaligned word load, addr 0x2:
  - No bus_req, misaligned pulses 1 cycle, stall never asserted.
- TIMEOUT=8, load with rvalid never asserted:
  - dout=0xDEADBEEF, bus_err pulses once, FSM back to IDLE.
  - A later load completes normally.
- rstn driven low while in WAIT, then a late bus_rvalid after release:
  - All outputs return to reset values.
  - Late rvalid ignored; dout stays 0.
